// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq
// Sequencing controller for a parallel-load/shift register. Words arrive over a
// valid/ready handshake. For each word the controller issues one load cycle
// (L), then exactly WIDTH shift cycles (Sh). The shift cycles can be paused
// with hold. It then pulses done for one cycle.
//
// Ports
//   clk       in   rising-edge clock shared with the shift register
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   producer presents a word on in_data
//   in_ready  out  controller can accept a word this cycle (IDLE or DONE)
//   in_data   in   word to serialize
//   in_si     in   serial fill bit for this word, sampled with in_data
//   hold      in   pauses shifting while high (registered before use)
//   D         out  registered copy of the accepted word
//   L         out  load strobe
//   Sh        out  shift strobe
//   SI        out  registered copy of in_si
//   busy      out  high in LOAD and SHIFT
//   done      out  one-cycle pulse after the last shift
//   bit_cnt   out  shifts completed for the current word
// -----------------------------------------------------------------------------
module shift_seq #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_si,
   input  logic             hold,
   output logic [WIDTH-1:0] D,
   output logic             L,
   output logic             Sh,
   output logic             SI,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] bit_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic             r_hold;
   logic [WIDTH-1:0] r_d;
   logic             r_si;
   logic [CNT_W-1:0] r_cnt;

   logic w_xfer;
   logic w_shift;
   logic w_last;

   // Ready only outside LOAD/SHIFT, so a transfer can occur only in IDLE or DONE.
   assign in_ready = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_xfer   = in_valid && in_ready;
   // Shift strobe and counter advance share one term, so the count always
   // equals the number of Sh cycles, even when hold toggles near the end.
   assign w_shift  = (r_state == S_SHIFT) && !r_hold;
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_hold  <= 1'b0;
         r_d     <= '0;
         r_si    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_hold <= hold;
         if (w_xfer) begin
            r_d     <= in_data;
            r_si    <= in_si;
            r_cnt   <= '0;
            r_state <= S_LOAD;
         end else begin
            case (r_state)
               S_LOAD:  r_state <= S_SHIFT;
               S_SHIFT: begin
                  if (w_shift) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                     if (w_last) r_state <= S_DONE;
                  end
               end
               S_DONE:  r_state <= S_IDLE;  // bit_cnt keeps WIDTH in IDLE
               default: r_state <= r_state;
            endcase
         end
      end
   end

   assign D       = r_d;
   assign SI      = r_si;
   assign bit_cnt = r_cnt;
   assign L       = (r_state == S_LOAD);
   assign Sh      = w_shift;
   assign busy    = (r_state == S_LOAD) || (r_state == S_SHIFT);
   assign done    = (r_state == S_DONE);

endmodule

// File: doc/shift_seq.md
# shift_seq

Sequencing controller that sits directly upstream of the 4-bit parallel-load/shift register. It accepts parallel words over a valid/ready handshake and drives the register's `D`, `L`, `Sh` and `SI` inputs. For each word it asserts one load cycle, then exactly `WIDTH` shift cycles, which can be paused by `hold`. It then pulses `done` so the producer or consumer can track word boundaries.

## Interface
- `WIDTH`, default 4: data word width and the number of shift cycles per word.
- `CNT_W`, default 3: bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk`  in  1  rising-edge clock shared with the shift register.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  controller can accept a word this cycle.
- `in_data`  in  WIDTH  word to serialize.
- `in_si`  in  1  serial fill bit for this word's shifts; sampled with `in_data`.
- `hold`  in  1  pauses shifting while high.
- `D`  out  WIDTH  parallel data to the register; registered copy of the accepted word.
- `L`  out  1  load strobe to the register.
- `Sh`  out  1  shift strobe to the register.
- `SI`  out  1  serial input to the register; registered copy of `in_si`.
- `busy`  out  1  high in LOAD and SHIFT.
- `done`  out  1  one-cycle pulse after the last shift.
- `bit_cnt`  out  CNT_W  number of shifts completed for the current word.

## Operation
- State machine: IDLE, LOAD, SHIFT, DONE.
- Transfer rule: a transfer occurs on a rising edge where `in_valid && in_ready`.
- `in_ready` is 1 in IDLE and DONE, and 0 in LOAD and SHIFT.
- On a transfer:
  - `D` <= `in_data`, `SI` <= `in_si`, `bit_cnt` <= 0.
  - Next state is LOAD.
- IDLE: no transfer keeps the state in IDLE.
- LOAD: `L`=1 and `Sh`=0 for exactly one cycle, then go to SHIFT unconditionally. `hold` is ignored in LOAD.
- SHIFT, `hold`=0: `Sh`=1 and `bit_cnt` increments on the edge.
- SHIFT, `hold`=1: `Sh`=0 and `bit_cnt` is frozen.
- SHIFT exit: when a shift edge takes `bit_cnt` to WIDTH, go to DONE.
- DONE: `done`=1 for one cycle and `bit_cnt` holds WIDTH.
  - Transfer in DONE: go straight to LOAD.
  - No transfer in DONE: go to IDLE, where `bit_cnt` holds WIDTH until the next transfer.
- `L`, `Sh`, `busy` and `done` are decoded from the registered state (plus registered `hold` gating for `Sh`).
  - `L` and `Sh` are never both 1.
  - `D` and `SI` are stable for the entire LOAD+SHIFT span of a word.
- Reset values, asserted asynchronously on `rst_n`=0:
  - state IDLE.
  - `D`=0, `SI`=0, `bit_cnt`=0.
  - `L`=0, `Sh`=0, `busy`=0, `done`=0.
  - `in_ready`=1.
- Reset mid-word abandons the word with no `done`. Once `rst_n` rises, the first rising edge is the first functional edge.
- `in_valid` while `in_ready`=0 is not accepted. The producer must hold the word until `in_ready`; `in_data` is not sampled while not ready.

## Timing
- Accept edge = cycle 0. LOAD is cycle 1 (`L`=1).
- With no hold, SHIFT occupies cycles 2..WIDTH+1 (`Sh`=1) and DONE is cycle WIDTH+2 (`done`=1).
- Throughput: back-to-back words, with a transfer in DONE, give one word per WIDTH+2 cycles. For WIDTH=4 that is 6 cycles.
- Hold: `hold` is registered, so `Sh` responds one cycle after `hold` changes. Each held SHIFT cycle extends the word by one cycle.
- Latency from `in_valid` in IDLE to `L`=1 is 1 cycle.
- Max shifts per word is exactly WIDTH. There is never an extra shift, even with `hold` toggling on the final shift cycle.

## Test plan
- Reset, then idle: `rst_n`=0 for 3 cycles, `in_valid`=0 → all outputs at reset values and `in_ready`=1; after release, state stays IDLE.
- Single word: `in_data`=4'b1101, `in_si`=0, one-cycle `in_valid` → `D`=1101; `L` high in cycle 1; `Sh` high in cycles 2–5; `bit_cnt` 0→4; `done` in cycle 6; then `in_ready`=1.
- Back-to-back: 4'b1101 then 4'b0011 with `in_si`=1, `in_valid` held → second accept in the DONE cycle (cycle 6); `L` in cycle 7; `SI`=1 from cycle 7; `done` again in cycle 12.
- Hold: `hold`=1 for 2 cycles starting mid-SHIFT after 2 shifts → `Sh` low for 2 cycles; `bit_cnt` frozen at 2; `done` delayed by 2 cycles; total shifts exactly 4.
- Ready backpressure: `in_valid`=1 with 4'b0110 during SHIFT of a prior word → not accepted until the DONE cycle; `D` unchanged before then.
- Reset mid-word: `rst_n`=0 asynchronously during SHIFT after 2 shifts → `Sh`, `busy`, `bit_cnt` and `D` cleared immediately; no `done` pulse; the next word is processed normally.
